// File: rtl/axi_up_pkg.sv
// Shared constants and types for the AXI4 responder memory.
// Burst codes, response codes and the controller state encoding.
package axi_up_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        WRESP,
        READ
    } state_t;

    // Codes are ordered so the numerically larger one is the worse one.
    function automatic logic [1:0] resp_max(
        input logic [1:0] a,
        input logic [1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_bus.sv
// Generic AXI4 bus bundle with master and slave views.
// Widths come from the interface parameters.
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 1
);
    localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_lock;
    logic [3:0]                aw_cache;
    logic [2:0]                aw_prot;
    logic [3:0]                aw_qos;
    logic [3:0]                aw_region;
    logic [AXI_USER_WIDTH-1:0] aw_user;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [AXI_STRB_WIDTH-1:0] w_strb;
    logic                      w_last;
    logic [AXI_USER_WIDTH-1:0] w_user;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [AXI_USER_WIDTH-1:0] b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_lock;
    logic [3:0]                ar_cache;
    logic [2:0]                ar_prot;
    logic [3:0]                ar_qos;
    logic [3:0]                ar_region;
    logic [AXI_USER_WIDTH-1:0] ar_user;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock,
        output aw_cache, aw_prot, aw_qos, aw_region, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock,
        output ar_cache, ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock,
        input  aw_cache, aw_prot, aw_qos, aw_region, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock,
        input  ar_cache, ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );

endinterface

// File: rtl/axi_up_mem_addr_gen.sv
// Next-beat address and out-of-window flag for one AXI burst beat.
// INCR wraps inside the memory window; WRAP folds at the burst span.
module axi_up_mem_addr_gen
    import axi_up_pkg::*;
#(
    parameter int unsigned    AW   = 32,
    parameter int unsigned    MB   = 12,
    parameter logic [AW-1:0]  BASE = '0
) (
    input  logic [AW-1:0] addr,
    input  logic [2:0]    size,
    input  logic [7:0]    len,
    input  logic [1:0]    burst,
    output logic [AW-1:0] nxt,
    output logic          oor
);

    logic [AW:0]   off;
    logic [AW-1:0] step;
    logic [AW-1:0] amask;
    logic [AW-1:0] inc;
    logic [AW-1:0] wmask;

    always_comb begin
        off   = {1'b0, addr} - {1'b0, BASE};
        oor   = off[AW] || ((off[AW-1:0] >> MB) != '0);
        step  = AW'(1) << size;
        amask = step - AW'(1);
        inc   = (addr & ~amask) + step;
        wmask = ((AW'(len) + AW'(1)) * step) - AW'(1);
        nxt   = addr;
        unique case (burst)
            BURST_INCR: nxt = {addr[AW-1:MB], inc[MB-1:0]};
            BURST_WRAP: nxt = (addr & ~wmask) | (inc & wmask);
            default:    nxt = addr;
        endcase
    end

endmodule

// File: rtl/axi_up_mem_slv.sv
// AXI4 responder backed by a word memory, one transaction at a time.
// Define AXI_UP_MEM_WRAP_EN to serve WRAP bursts; otherwise they get SLVERR.
module axi_up_mem_slv
    import axi_up_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic  ACLK,
    input  logic  ARESETn,
    AXI_BUS.Slave slv,
    output logic  busy_o
);

    localparam int unsigned AW = $bits(slv.aw_addr);
    localparam int unsigned DW = $bits(slv.w_data);
    localparam int unsigned IW = $bits(slv.aw_id);
    localparam int unsigned NB = DW / 8;
    localparam int unsigned BB = $clog2(NB);
    localparam int unsigned WB = $clog2(MEM_WORDS);
    localparam int unsigned MB = WB + BB;

    state_t          state;
    state_t          state_nxt;
    logic            rdy_en;
    logic            prio_wr;
    logic [IW-1:0]   id_q;
    logic [AW-1:0]   addr_q;
    logic [7:0]      len_q;
    logic [7:0]      cnt_q;
    logic [2:0]      size_q;
    logic [1:0]      burst_q;
    logic [1:0]      bresp_q;

    logic [AW-1:0]   addr_nxt;
    logic            oor;
    logic            wrap_err;
    logic            beat_ok;
    logic [1:0]      beat_resp;
    logic [1:0]      w_resp;
    logic            last_beat;
    logic [WB-1:0]   widx;
    logic            aw_hs;
    logic            ar_hs;
    logic            w_hs;
    logic            r_hs;

    logic [DW-1:0]   mem [MEM_WORDS];

    axi_up_mem_addr_gen #(
        .AW   (AW),
        .MB   (MB),
        .BASE (AW'(BASE_ADDR))
    ) u_addr_gen (
        .addr  (addr_q),
        .size  (size_q),
        .len   (len_q),
        .burst (burst_q),
        .nxt   (addr_nxt),
        .oor   (oor)
    );

`ifdef AXI_UP_MEM_WRAP_EN
    assign wrap_err = 1'b0;
`else
    assign wrap_err = (burst_q == BURST_WRAP);
`endif

    assign beat_ok   = !oor && !wrap_err;
    assign beat_resp = oor      ? RESP_DECERR :
                       wrap_err ? RESP_SLVERR : RESP_OKAY;
    assign last_beat = (cnt_q == len_q);
    assign widx      = addr_q[MB-1:BB];
    // A WLAST that disagrees with the beat count poisons the burst.
    assign w_resp    = resp_max(beat_resp,
                       (slv.w_last != last_beat) ? RESP_SLVERR : RESP_OKAY);

    // Ready waits for valid so an idle port shows no READY at all.
    assign slv.aw_ready = rdy_en && (state == IDLE) && slv.aw_valid
                          && (prio_wr || !slv.ar_valid);
    assign slv.ar_ready = rdy_en && (state == IDLE) && slv.ar_valid
                          && (!prio_wr || !slv.aw_valid);
    assign slv.w_ready  = (state == WRITE);
    assign slv.b_valid  = (state == WRESP);
    assign slv.b_resp   = slv.b_valid ? bresp_q : RESP_OKAY;
    assign slv.b_id     = id_q;
    assign slv.b_user   = '0;
    assign slv.r_valid  = (state == READ);
    assign slv.r_data   = (slv.r_valid && beat_ok) ? mem[widx] : '0;
    assign slv.r_resp   = slv.r_valid ? beat_resp : RESP_OKAY;
    assign slv.r_last   = slv.r_valid && last_beat;
    assign slv.r_id     = id_q;
    assign slv.r_user   = '0;
    assign busy_o       = (state != IDLE);

    assign aw_hs = slv.aw_valid && slv.aw_ready;
    assign ar_hs = slv.ar_valid && slv.ar_ready;
    assign w_hs  = slv.w_valid && slv.w_ready;
    assign r_hs  = slv.r_valid && slv.r_ready;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (aw_hs) begin
                    state_nxt = WRITE;
                end else if (ar_hs) begin
                    state_nxt = READ;
                end
            end
            WRITE: begin
                if (w_hs && (slv.w_last || last_beat)) begin
                    state_nxt = WRESP;
                end
            end
            WRESP: begin
                if (slv.b_ready) begin
                    state_nxt = IDLE;
                end
            end
            READ: begin
                if (r_hs && last_beat) begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rdy_en  <= 1'b0;
            prio_wr <= 1'b1;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            bresp_q <= RESP_OKAY;
        end else begin
            rdy_en <= 1'b1;
            if (aw_hs) begin
                prio_wr <= 1'b0;
                id_q    <= slv.aw_id;
                addr_q  <= slv.aw_addr;
                len_q   <= slv.aw_len;
                size_q  <= slv.aw_size;
                burst_q <= slv.aw_burst;
                cnt_q   <= '0;
                bresp_q <= RESP_OKAY;
            end else if (ar_hs) begin
                prio_wr <= 1'b1;
                id_q    <= slv.ar_id;
                addr_q  <= slv.ar_addr;
                len_q   <= slv.ar_len;
                size_q  <= slv.ar_size;
                burst_q <= slv.ar_burst;
                cnt_q   <= '0;
            end else if (w_hs) begin
                cnt_q   <= cnt_q + 8'd1;
                addr_q  <= addr_nxt;
                bresp_q <= resp_max(bresp_q, w_resp);
            end else if (r_hs) begin
                cnt_q   <= cnt_q + 8'd1;
                addr_q  <= addr_nxt;
            end
        end
    end

    // Storage keeps its contents across reset.
    always_ff @(posedge ACLK) begin
        if (w_hs && beat_ok) begin
            for (int b = 0; b < NB; b++) begin
                if (slv.w_strb[b]) begin
                    mem[widx][8*b +: 8] <= slv.w_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: doc/axi_up_mem_slv.md
AXI_UP_MEM_SLV -- requirements
Module: axi_up_mem_slv

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, meaning the number of data words of internal storage (power of two).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address of word 0 (MEM_WORDS*bytes-per-word aligned).
REQ-003 SHALL have port ACLK, input, 1 bit: the only clock, rising edge.
REQ-004 SHALL have port ARESETn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port slv, AXI_BUS.Slave, widths from the interface parameters: AXI4 responder port (AW/W/B/AR/R).
REQ-006 SHALL have port busy_o, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-007 SHALL implement FSM states IDLE, WRITE, WRESP, READ; only one transaction is in flight at a time.
REQ-008 IDLE SHALL assert AWREADY and ARREADY per REQ-009; AW handshake -> WRITE, AR handshake -> READ; address, ID, LEN, SIZE and BURST are latched on the handshake.
REQ-009 SHALL arbitrate simultaneous AWVALID and ARVALID in IDLE with alternating priority (first after reset: write); the loser's READY stays low that cycle.
REQ-010 WRITE SHALL hold WREADY high, accept one beat per cycle, write bytes whose WSTRB bit is 1, and leave other bytes unchanged.
REQ-011 On the beat with WLAST, or after LEN+1 beats, SHALL go to WRESP; a WLAST/count mismatch SHALL give BRESP SLVERR.
REQ-012 WRESP SHALL assert BVALID the cycle after the last W beat, with BID = latched AWID, hold it until BREADY, then return to IDLE.
REQ-013 READ SHALL assert RVALID one cycle after the AR handshake, then sustain one beat per cycle while RREADY is high; RLAST on beat LEN; RID = latched ARID; RDATA and RVALID are held stable while RREADY is low.
REQ-014 Beat address SHALL be held constant for FIXED and incremented by 2^SIZE for INCR; INCR crossing the last word SHALL wrap to word 0 (modulo MEM_WORDS).
REQ-015 Any beat outside [BASE_ADDR, BASE_ADDR+MEM_WORDS*bytes) SHALL get response DECERR; writes are dropped and RDATA is zero; other beats respond OKAY.
REQ-016 BRESP SHALL be the worst response over all beats of the burst (DECERR > SLVERR > OKAY).
REQ-017 All user and region outputs SHALL be driven to zero; a write issued immediately after a read to the same word SHALL be observed by the next read.

Reset
REQ-018 While ARESETn is low: AWREADY, WREADY, ARREADY, BVALID, RVALID and busy_o SHALL be 0, BRESP/RRESP/RDATA/BID/RID 0, FSM IDLE, arbitration priority = write.
REQ-019 Reset mid-burst SHALL abandon the transaction; no B or R beat for it is produced after release.
REQ-020 Storage contents SHALL NOT be reset.

Configuration
REQ-021 With AXI_UP_MEM_WRAP_EN defined: WRAP bursts SHALL be supported, with the address wrapping at the (LEN+1)*2^SIZE aligned boundary.
REQ-022 Without AXI_UP_MEM_WRAP_EN: WRAP bursts SHALL complete the full handshake with SLVERR on every beat, writes dropped and RDATA zero.

Structure
REQ-023 Package axi_up_pkg SHALL hold the burst-type and response-code constants and the FSM state typedef.
REQ-024 Sub-module axi_up_mem_addr_gen SHALL compute the next beat address (FIXED/INCR/WRAP) and the out-of-range flag, purely combinationally.

Verification
REQ-025 Reset: after reset release all VALID/READY outputs are 0 and busy_o is 0.
REQ-026 INCR write, AW addr BASE+0x10, LEN=3, WSTRB all ones, then INCR read of same -> B OKAY one cycle after WLAST; read returns the 4 words in order, RLAST on beat 4.
REQ-027 Write 0xFFFFFFFF, then write 0x000000AA with WSTRB=0001 to the same word, then read it -> 0xFFFFFFAA.
REQ-028 AWVALID and ARVALID asserted in the same cycle twice -> write granted first, read granted second.
REQ-029 Read at BASE + MEM_WORDS*bytes -> RRESP DECERR, RDATA 0; WRAP LEN=3 read at +0x08 -> SLVERR without macro; word order 2,3,0,1 with macro.
REQ-030 RREADY held low 5 cycles mid-burst, then ARESETn pulsed low -> RDATA stable while stalled; no further R beats after reset release.
